// File: rtl/worm_pkg.sv
// rtl/worm_pkg.sv - shared types and constants for the worm scan engine
package worm_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_SCAN   = 2'd2,
    S_RESULT = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] in_ip;
    logic [31:0] out_ip;
    logic [7:0]  proto;
    logic [15:0] in_port;
    logic [15:0] out_port;
  } hdr_t;

  localparam int STRIP_IDX_W  = 3;
  localparam int BLOOM_HASH_W = 6;
  localparam logic [7:0] PROTO_TCP = 8'd6;
  localparam logic [7:0] PROTO_UDP = 8'd17;

  // Signature filter: only hash positions 18 and 45 are populated.
  localparam logic [63:0] BLOOM_FILTER = 64'h0000_2000_0004_0000;

  function automatic logic [BLOOM_HASH_W-1:0] bloom_h2(input logic [BLOOM_HASH_W-1:0] h1);
    return {h1[2:0], h1[5:3]};
  endfunction

endpackage

// File: rtl/bloom_set.sv
// rtl/bloom_set.sv - one bloom lane: two-probe lookup with registered hit
module bloom_set
  import worm_pkg::*;
#(
  parameter int IDX_W  = STRIP_IDX_W,
  parameter int LANE_W = 56
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [IDX_W+LANE_W-1:0] key_i,
  output logic                    match_o
);

  localparam int KEY_W = IDX_W + LANE_W;

  logic [BLOOM_HASH_W-1:0] h1;
  logic [BLOOM_HASH_W-1:0] h2;
  logic                    hit_d;
  logic                    hit_q;

  always_comb begin
    h1 = '0;
    for (int i = 0; i < KEY_W; i++) begin
      h1 = h1 ^ (BLOOM_HASH_W'(key_i[i]) << (i % BLOOM_HASH_W));
    end
    h2    = bloom_h2(h1);
    hit_d = BLOOM_FILTER[h1] && BLOOM_FILTER[h2];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) hit_q <= 1'b0;
    else       hit_q <= hit_d;
  end

  assign match_o = hit_q;

endmodule

// File: rtl/header_police.sv
// rtl/header_police.sv - header screen: protocol/IP filter and strip-index fold
module header_police
  import worm_pkg::*;
#(
  parameter int IDX_W = STRIP_IDX_W
) (
  input  hdr_t             hdr_i,
  output logic             match_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [31:0] ports;

  assign ports = {hdr_i.in_port, hdr_i.out_port};

  always_comb begin
    match_o = ((hdr_i.proto == PROTO_TCP) || (hdr_i.proto == PROTO_UDP))
              && (hdr_i.in_ip != hdr_i.out_ip);
    idx_o = '0;
    // Port bit i lands on index bit i mod IDX_W.
    for (int i = 0; i < 32; i++) begin
      idx_o = idx_o ^ (IDX_W'(ports[i]) << (i % IDX_W));
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int CID_W       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [CID_W-1:0]       ptr_i,
  output logic [NUM_CLIENTS-1:0] gnt_o,
  output logic [CID_W-1:0]       id_o
);

  int   cand;
  logic found;

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cand = (int'(ptr_i) + i) % NUM_CLIENTS;
      if (!found && (|(req_i & (NUM_CLIENTS'(1) << cand)))) begin
        found = 1'b1;
        gnt_o = NUM_CLIENTS'(1) << cand;
        id_o  = CID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/worm_scan_engine.sv
// rtl/worm_scan_engine.sv - multi-client packet capture, header screen and bloom scan
module worm_scan_engine
  import worm_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int NUM_LANES   = 10,
  parameter int LANE_W      = 56,
  parameter int IDX_W       = STRIP_IDX_W,
  parameter int SCAN_CYCLES = 4,
  parameter int CNT_W       = 16,
  parameter int CID_W       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_CLIENTS-1:0]      req_i,
  output logic [NUM_CLIENTS-1:0]      gnt_o,
  input  logic [NUM_LANES*LANE_W-1:0] payload_i,
  input  logic [31:0]                 in_ip_i,
  input  logic [31:0]                 out_ip_i,
  input  logic [7:0]                  proto_i,
  input  logic [15:0]                 in_port_i,
  input  logic [15:0]                 out_port_i,
  output logic                        busy_o,
  output logic                        valid_o,
  output logic [CID_W-1:0]            clientid_o,
  output logic                        match_o,
  output logic [NUM_LANES-1:0]        lane_match_o,
  output logic [CNT_W-1:0]            match_cnt_o,
  input  logic                        clr_cnt_i
);

  localparam int SCW = $clog2(SCAN_CYCLES);
  localparam int PW  = NUM_LANES * LANE_W;

  state_e                 state_q, state_d;
  logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;
  logic [CID_W-1:0]       cid_q, cid_d;
  logic [CID_W-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]          payload_q, payload_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [SCW-1:0]         scan_q, scan_d;
  logic [NUM_LANES-1:0]   lane_q, lane_d;
  logic                   match_q, match_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   cnt_inc;

  hdr_t                   hdr;
  logic                   hp_match;
  logic [IDX_W-1:0]       hp_idx;
  logic [NUM_CLIENTS-1:0] arb_gnt;
  logic [CID_W-1:0]       arb_id;
  logic [NUM_LANES-1:0]   lane_hit;

  assign hdr = '{in_ip: in_ip_i, out_ip: out_ip_i, proto: proto_i,
                 in_port: in_port_i, out_port: out_port_i};

  header_police #(.IDX_W(IDX_W)) u_header_police (
    .hdr_i   (hdr),
    .match_o (hp_match),
    .idx_o   (hp_idx)
  );

  rr_arbiter #(.NUM_CLIENTS(NUM_CLIENTS), .CID_W(CID_W)) u_rr_arbiter (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .id_o  (arb_id)
  );

  // Lane keys come only from capture registers, so they stay frozen through SCAN.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    bloom_set #(.IDX_W(IDX_W), .LANE_W(LANE_W)) u_bloom_set (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .key_i   ({idx_q, payload_q[k*LANE_W +: LANE_W]}),
      .match_o (lane_hit[k])
    );
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cid_d     = cid_q;
    ptr_d     = ptr_q;
    payload_d = payload_q;
    idx_d     = idx_q;
    scan_d    = scan_q;
    lane_d    = lane_q;
    match_d   = match_q;
    cnt_d     = cnt_q;
    cnt_inc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          gnt_d   = arb_gnt;
          cid_d   = arb_id;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        gnt_d     = '0;
        payload_d = payload_i;
        idx_d     = hp_idx;
        ptr_d     = (cid_q == CID_W'(NUM_CLIENTS-1)) ? '0 : cid_q + 1'b1;
        if (hp_match) begin
          scan_d  = '0;
          state_d = S_SCAN;
        end else begin
          lane_d  = '0;
          match_d = 1'b0;
          state_d = S_RESULT;
        end
      end
      S_SCAN: begin
        scan_d = scan_q + 1'b1;
        if (scan_q == SCW'(SCAN_CYCLES-1)) begin
          lane_d  = lane_hit;
          match_d = |lane_hit;
          cnt_inc = |lane_hit;
          state_d = S_RESULT;
        end
      end
      S_RESULT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // The counter moves on the edge that enters RESULT, so it is current while valid_o is high.
    if (clr_cnt_i)                    cnt_d = '0;
    else if (cnt_inc && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      cid_q     <= '0;
      ptr_q     <= '0;
      payload_q <= '0;
      idx_q     <= '0;
      scan_q    <= '0;
      lane_q    <= '0;
      match_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cid_q     <= cid_d;
      ptr_q     <= ptr_d;
      payload_q <= payload_d;
      idx_q     <= idx_d;
      scan_q    <= scan_d;
      lane_q    <= lane_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign busy_o       = (state_q != S_IDLE);
  assign valid_o      = (state_q == S_RESULT);
  assign clientid_o   = cid_q;
  assign match_o      = match_q;
  assign lane_match_o = lane_q;
  assign match_cnt_o  = cnt_q;

endmodule
